divisible_n_serial: RTL and testbench
=====================================

Name: divisible_n_serial

Overview:
- Bit-serial divisibility checker. A WIDTH-bit unsigned operand arrives one bit per accepted cycle, MSB first by default.
- The block keeps a running remainder modulo DIVISOR and reports the final remainder and a divisible flag.
- It is the parametrised, sequential successor to the fixed 4-bit combinational divisibility checks in the lab datapath. It sits behind a serial input source such as a switch scanner or shift register.

Parameters:
- DIVISOR, 6, modulus; integer >= 2.
- WIDTH, 8, operand length in bits; >= 1.
- REM_W, 3, remainder width; must satisfy 2**REM_W >= DIVISOR.
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new operand; sampled only in IDLE or DONE.
- bit_in  input  1  serial operand bit.
- bit_valid  input  1  bit_in is valid this cycle; ignored outside SHIFT.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- divisible  output  1  1 iff the final remainder == 0; held until the next start.
- remainder  output  REM_W  final operand mod DIVISOR; held until the next start.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst. All state is registered.
- Reset values:
  - state = IDLE.
  - rem_r = 0, cnt = 0.
  - busy = 0, done = 0, divisible = 0, remainder = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> SHIFT; rem_r <= 0, cnt <= 0.
  - bit_valid is ignored.
- SHIFT:
  - Each cycle with bit_valid=1: t = 2*rem_r + bit_in, computed at REM_W+1 bits. rem_r <= (t >= DIVISOR) ? t-DIVISOR : t. cnt <= cnt+1.
  - A single conditional subtract suffices because t < 2*DIVISOR. No divider or modulo operator.
  - bit_valid=0 is a bubble: no change to rem_r or cnt; stay in SHIFT.
  - Accepting the bit with cnt == WIDTH-1 -> DONE. On that edge, remainder and divisible load from the next-remainder value.
  - start during SHIFT is ignored.
- DONE:
  - Lasts exactly one cycle; done=1 and busy=0.
  - start=1 in this cycle -> SHIFT (back-to-back operands; rem_r and cnt cleared). Otherwise -> IDLE.
- Latency: done is asserted in the cycle after the edge that accepted the last bit. Minimum operand period is WIDTH+1 cycles.
- remainder and divisible change only on the SHIFT->DONE edge or on reset. They stay stable through IDLE and through the following SHIFT.
- Reset mid-operation aborts immediately:
  - Return to IDLE, all outputs zero.
  - No done pulse for the aborted operand.
- WIDTH=1: a single accepted bit goes straight to DONE. Result is bit_in mod DIVISOR.

Optional Feature:
- Macro: DIVN_LSB_FIRST_EN.
- Defined: operand arrives LSB first. Add a weight register w (REM_W bits), reset and cleared on start to 1 mod DIVISOR.
  - Per accepted bit: rem_r <= (rem_r + (bit_in ? w : 0)) mod DIVISOR, using one conditional subtract.
  - Also per accepted bit: w <= (2*w) mod DIVISOR, using one conditional subtract.
  - Handshake, FSM, latency and outputs are otherwise identical.
- Undefined: MSB-first only; no w register is synthesised.

Test Plan:
- DIVISOR=6, WIDTH=8, operand 0x5A (90), continuous bit_valid -> done on cycle 9 after start accepted; divisible=1, remainder=0.
- Operand 0xFF (255), with bit_valid low for 3 cycles after the 4th bit -> done delayed by 3 cycles; divisible=0, remainder=3. Outputs stable until the next start.
- Back-to-back: start held high during DONE of 0x5B (91 -> rem 1, div 0), next operand 0x0C (12) -> second done exactly WIDTH+1 cycles after the first; rem 0, div 1.
- rst asserted after 5 bits of 0x5A -> outputs 0 asynchronously, state IDLE, no done. A subsequent full 0x5B gives rem 1.
- start pulsed during SHIFT and bit_valid pulsed in IDLE -> no effect on the result of the current or next operand.
- DIVISOR=3, WIDTH=4, exhaustive 0..15, in both MSB-first and DIVN_LSB_FIRST_EN builds -> remainder == value % 3 and divisible == (value % 3 == 0) for all 16 values.

Source files
------------

// File: rtl/divisible_n_serial.sv
// Bit-serial divisibility checker: keeps a running remainder of a WIDTH-bit operand modulo DIVISOR.
// Define DIVN_LSB_FIRST_EN for LSB-first operands (adds a weight register); default is MSB first.
module divisible_n_serial #(
  parameter int DIVISOR = 6,
  parameter int WIDTH   = 8,
  parameter int REM_W   = 3,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             divisible,
  output logic [REM_W-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [REM_W:0]   DIV_EXT  = (REM_W+1)'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_r, state_s;
  logic [REM_W-1:0]   rem_r, rem_s, rem_nx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               res_load_s;
  logic               busy_r, done_r, divisible_r;
  logic [REM_W-1:0]   remainder_r;

`ifdef DIVN_LSB_FIRST_EN
  localparam logic [REM_W-1:0] W_INIT = REM_W'(1 % DIVISOR);

  logic [REM_W-1:0] w_r, w_s, w_nx_s;
  logic [REM_W:0]   sum_s, dbl_s;

  // Next remainder and weight for an accepted LSB-first bit; both sums stay below 2*DIVISOR
  always_comb begin
    sum_s = {1'b0, rem_r} + (bit_in ? {1'b0, w_r} : {(REM_W+1){1'b0}});
    if (sum_s >= DIV_EXT) begin
      rem_nx_s = REM_W'(sum_s - DIV_EXT);
    end else begin
      rem_nx_s = sum_s[REM_W-1:0];
    end
    dbl_s = {w_r, 1'b0};
    if (dbl_s >= DIV_EXT) begin
      w_nx_s = REM_W'(dbl_s - DIV_EXT);
    end else begin
      w_nx_s = dbl_s[REM_W-1:0];
    end
  end
`else
  logic [REM_W:0] t_s;

  // Next remainder for an accepted MSB-first bit: 2*rem + bit is below 2*DIVISOR
  always_comb begin
    t_s = {rem_r, bit_in};
    if (t_s >= DIV_EXT) begin
      rem_nx_s = REM_W'(t_s - DIV_EXT);
    end else begin
      rem_nx_s = t_s[REM_W-1:0];
    end
  end
`endif

  // Next-state, datapath update and result-load decision
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    cnt_s      = cnt_r;
    res_load_s = 1'b0;
`ifdef DIVN_LSB_FIRST_EN
    w_s        = w_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = SHIFT;
          rem_s   = {REM_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
`ifdef DIVN_LSB_FIRST_EN
          w_s     = W_INIT;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          rem_s = rem_nx_s;
          cnt_s = cnt_r + CNT_W'(1);
`ifdef DIVN_LSB_FIRST_EN
          w_s   = w_nx_s;
`endif
          if (cnt_r == CNT_LAST) begin
            state_s    = DONE;
            res_load_s = 1'b1;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rem_r       <= {REM_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      divisible_r <= 1'b0;
      remainder_r <= {REM_W{1'b0}};
`ifdef DIVN_LSB_FIRST_EN
      w_r         <= W_INIT;
`endif
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == SHIFT);
      done_r  <= (state_s == DONE);
`ifdef DIVN_LSB_FIRST_EN
      w_r     <= w_s;
`endif
      if (res_load_s) begin
        remainder_r <= rem_s;
        divisible_r <= (rem_s == {REM_W{1'b0}});
      end else begin
        remainder_r <= remainder_r;
        divisible_r <= divisible_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign divisible = divisible_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_divisible_n_serial.sv
// Self-checking bench for divisible_n_serial: randomized operands against value % DIVISOR.
// Bit order follows DIVN_LSB_FIRST_EN, matching the DUT build.
module tb_divisible_n_serial;

  logic       clk, rst;
  logic       start, bit_in, bit_valid;
  logic       busy, done, divisible;
  logic [2:0] remainder;

  logic       s_start, s_bit_in, s_bit_valid;
  logic       s_busy, s_done, s_divisible;
  logic [1:0] s_remainder;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cyc;
  int prev_rem;
  int prev_div;

  divisible_n_serial #(.DIVISOR(6), .WIDTH(8), .REM_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy), .done(done), .divisible(divisible), .remainder(remainder)
  );

  divisible_n_serial #(.DIVISOR(3), .WIDTH(4), .REM_W(2), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .bit_in(s_bit_in), .bit_valid(s_bit_valid),
    .busy(s_busy), .done(s_done), .divisible(s_divisible), .remainder(s_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // i-th transmitted bit of a width-bit operand
  function automatic logic bit_at(input int val, input int i, input int width);
`ifdef DIVN_LSB_FIRST_EN
    return 1'((val >> i) & 1);
`else
    return 1'((val >> (width - 1 - i)) & 1);
`endif
  endfunction

  task automatic idle_cycles(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      bit_valid = noise ? 1'($urandom) : 1'b0;
      bit_in    = 1'($urandom);
      @(posedge clk); #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_rem_hold", remainder, prev_rem);
      check("idle_div_hold", divisible, prev_div);
    end
    bit_valid = 1'b0;
  endtask

  // One operand on the main DUT; entered in IDLE or DONE, left in DONE
  task automatic run_op(input int val, input int gap_at, input int gap_len, input bit noise);
    int exp_r;
    int nb;
    exp_r     = val % 6;
    start     = 1'b1;
    bit_valid = noise ? 1'($urandom) : 1'b0;
    bit_in    = 1'($urandom);
    @(posedge clk); #1;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("shift_rem_hold", remainder, prev_rem);
    for (int i = 0; i < 8; i++) begin
      nb = (i == gap_at) ? gap_len : 0;
      if (noise) nb += $urandom_range(0, 2);
      for (int g = 0; g < nb; g++) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        start     = noise ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
        check("bubble_done", done, 0);
        check("bubble_busy", busy, 1);
        check("bubble_rem_hold", remainder, prev_rem);
        check("bubble_div_hold", divisible, prev_div);
      end
      bit_valid = 1'b1;
      bit_in    = bit_at(val, i, 8);
      start     = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      if (i < 7) begin
        check("shift_done", done, 0);
        check("shift_busy", busy, 1);
      end
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("remainder", remainder, exp_r);
    check("divisible", divisible, (exp_r == 0) ? 1 : 0);
    done_cyc = cyc;
    prev_rem = exp_r;
    prev_div = (exp_r == 0) ? 1 : 0;
  endtask

  task automatic run_small(input int val);
    int exp_r;
    exp_r   = val % 3;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_bit_valid = 1'b1;
      s_bit_in    = bit_at(val, i, 4);
      @(posedge clk); #1;
    end
    s_bit_valid = 1'b0;
    check("small_done", s_done, 1);
    check("small_rem", s_remainder, exp_r);
    check("small_div", s_divisible, (exp_r == 0) ? 1 : 0);
  endtask

  initial begin
    int t1;
    int v;
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    s_start = 1'b0; s_bit_in = 1'b0; s_bit_valid = 1'b0;
    prev_rem = 0; prev_div = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div", divisible, 0);
    check("reset_rem", remainder, 0);
    rst = 1'b0;
    idle_cycles(2, 1'b1);

    run_op(8'h5A, -1, 0, 1'b0);
    idle_cycles(3, 1'b1);
    run_op(8'hFF, 4, 3, 1'b0);
    idle_cycles(4, 1'b1);

    // Back-to-back: start sampled in the DONE cycle
    run_op(8'h5B, -1, 0, 1'b0);
    t1 = done_cyc;
    run_op(8'h0C, -1, 0, 1'b0);
    check("b2b_period", done_cyc - t1, 9);
    idle_cycles(2, 1'b0);

    run_op(8'hFF, -1, 0, 1'b0);
    idle_cycles(1, 1'b0);

    // Abort after 5 bits of 0x5A
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = bit_at(8'h5A, i, 8);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #2;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rem", remainder, 0);
    bit_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    prev_rem = 0; prev_div = 0;
    idle_cycles(3, 1'b0);
    run_op(8'h5B, -1, 0, 1'b0);
    idle_cycles(2, 1'b1);

    for (int k = 0; k < 20; k++) begin
      v = $urandom_range(0, 255);
      run_op(v, -1, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), 1'b1);
    end

    for (int k = 0; k < 16; k++) begin
      run_small(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
